// File: rtl/alu.sv
// RV32I/M integer ALU for the execute stage: decodes OP / OP-IMM words and
// registers the result one cycle later, flagging anything it cannot execute.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] code,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] rd,
    output logic        illegal
);
    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic [6:0]         w_funct7;
    logic               w_is_r;
    logic               w_is_i;
    logic [31:0]        w_op2;
    logic [4:0]         w_shamt;
    logic signed [31:0] w_rs1_s;
    logic signed [31:0] w_op2_s;
    logic [31:0]        w_mul;
    logic [31:0]        w_res;
    logic               w_ill;
    logic               w_unused_regnums;

    assign w_opcode = code[6:0];
    assign w_funct3 = code[14:12];
    assign w_funct7 = code[31:25];
    assign w_is_r   = (w_opcode == OPC_OP);
    assign w_is_i   = (w_opcode == OPC_IMM);
    assign w_op2    = w_is_i ? {{20{code[31]}}, code[31:20]} : rs2;
    assign w_shamt  = w_op2[4:0];
    assign w_rs1_s  = $signed(rs1);
    assign w_op2_s  = $signed(w_op2);
    assign w_mul    = rs1 * w_op2;

    // Register numbers are resolved outside; only the operand values matter here.
    assign w_unused_regnums = ^code[19:7];

    // imm[11:5] of OP-IMM sits in the same bits as funct7, so shift checks are shared.
    always_comb begin
        w_res = '0;
        w_ill = 1'b0;
        case (w_funct3)
            3'b000: begin
                if (w_is_i || w_funct7 == F7_BASE) w_res = rs1 + w_op2;
                else if (w_funct7 == F7_ALT)       w_res = rs1 - w_op2;
                else if (w_funct7 == F7_MUL)       w_res = w_mul;
                else                               w_ill = 1'b1;
            end
            3'b001: begin
                if (w_funct7 == F7_BASE) w_res = rs1 << w_shamt;
                else                     w_ill = 1'b1;
            end
            3'b101: begin
                if (w_funct7 == F7_BASE)     w_res = rs1 >> w_shamt;
                else if (w_funct7 == F7_ALT) w_res = w_rs1_s >>> w_shamt;
                else                         w_ill = 1'b1;
            end
            default: begin
                if (w_is_i || w_funct7 == F7_BASE) begin
                    case (w_funct3)
                        3'b010:  w_res = {31'd0, w_rs1_s < w_op2_s};
                        3'b011:  w_res = {31'd0, rs1 < w_op2};
                        3'b100:  w_res = rs1 ^ w_op2;
                        3'b110:  w_res = rs1 | w_op2;
                        default: w_res = rs1 & w_op2;
                    endcase
                end else begin
                    w_ill = 1'b1;
                end
            end
        endcase
        if (!w_is_r && !w_is_i) w_ill = 1'b1;
        if (w_ill) w_res = '0;
    end

    // Result register: single pipeline stage to write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd      <= '0;
            illegal <= 1'b0;
        end else begin
            rd      <= w_res;
            illegal <= w_ill;
        end
    end
endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed cases with known answers, then random instructions
// against a mnemonic-level reference model.
module tb_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] code = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [31:0] rd;
    logic        illegal;

    int n_chk  = 0;
    int n_pass = 0;

    alu dut (
        .clk     (clk),
        .rst     (rst),
        .code    (code),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Reference: name the instruction, then evaluate it with plain arithmetic.
    task automatic model(input logic [31:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ill);
        string       op;
        logic [6:0]  f7;
        logic [31:0] y;
        logic [63:0] wide;
        int          sh;
        f7 = c[31:25];
        op = "";
        y  = b;
        if (c[6:0] == 7'h33) begin
            case (c[14:12])
                3'd0: op = (f7 == 7'h00) ? "ADD" : (f7 == 7'h20) ? "SUB" : (f7 == 7'h01) ? "MUL" : "";
                3'd1: op = (f7 == 7'h00) ? "SLL" : "";
                3'd2: op = (f7 == 7'h00) ? "SLT" : "";
                3'd3: op = (f7 == 7'h00) ? "SLTU" : "";
                3'd4: op = (f7 == 7'h00) ? "XOR" : "";
                3'd5: op = (f7 == 7'h00) ? "SRL" : (f7 == 7'h20) ? "SRA" : "";
                3'd6: op = (f7 == 7'h00) ? "OR" : "";
                3'd7: op = (f7 == 7'h00) ? "AND" : "";
            endcase
        end else if (c[6:0] == 7'h13) begin
            y = {{20{c[31]}}, c[31:20]};
            case (c[14:12])
                3'd0: op = "ADD";
                3'd1: op = (f7 == 7'h00) ? "SLL" : "";
                3'd2: op = "SLT";
                3'd3: op = "SLTU";
                3'd4: op = "XOR";
                3'd5: op = (f7 == 7'h00) ? "SRL" : (f7 == 7'h20) ? "SRA" : "";
                3'd6: op = "OR";
                3'd7: op = "AND";
            endcase
        end
        sh  = int'(y % 32);
        ill = 1'b0;
        case (op)
            "ADD":  r = a + y;
            "SUB":  r = a - y;
            "MUL":  begin wide = {32'd0, a} * {32'd0, y}; r = wide[31:0]; end
            "SLL":  r = a << sh;
            "SRL":  r = a >> sh;
            "SRA":  begin wide = {{32{a[31]}}, a} >> sh; r = wide[31:0]; end
            "SLT":  r = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
            "SLTU": r = (a < y) ? 32'd1 : 32'd0;
            "XOR":  r = a ^ y;
            "OR":   r = a | y;
            "AND":  r = a & y;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endtask

    task automatic step(input logic [31:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_rd, input logic exp_ill, input string tag);
        code = c;
        rs1  = a;
        rs2  = b;
        @(posedge clk);
        #1;
        chk(rd, exp_rd, {tag, ".rd"});
        chk({31'd0, illegal}, {31'd0, exp_ill}, {tag, ".illegal"});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] c, a, b, er;
        logic        ei;
        logic [31:0] edge_vals [5];
        edge_vals = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

        #2;
        chk(rd, 32'd0, "reset.rd");
        chk({31'd0, illegal}, 32'd0, "reset.illegal");
        code = 32'h00410033; rs1 = 32'd2; rs2 = 32'd4;
        @(posedge clk); #1;
        chk(rd, 32'd0, "reset_hold.rd");
        #3 rst = 1'b0;

        step(32'h00410033, 32'd2, 32'd4, 32'd6, 1'b0, "add");
        step(32'h40410033, 32'd2, 32'd4, 32'hFFFFFFFE, 1'b0, "sub");
        step(32'h02410033, 32'd2, 32'd4, 32'd8, 1'b0, "mul");
        step(32'h00417033, 32'd2, 32'd4, 32'd0, 1'b0, "and");
        step(32'h00416033, 32'd2, 32'd6, 32'd6, 1'b0, "or");
        step(32'h00414033, 32'd2, 32'd6, 32'd4, 1'b0, "xor");
        step(32'h00412033, 32'hFFFFFFFB, 32'd3, 32'd1, 1'b0, "slt");
        step(32'h00413033, 32'hFFFFFFFB, 32'd3, 32'd0, 1'b0, "sltu");
        step(32'h40415033, 32'hFFFFFFFA, 32'd1, 32'hFFFFFFFD, 1'b0, "sra");
        step(32'h00415033, 32'd3, 32'd1, 32'd1, 1'b0, "srl");
        step(32'h00411033, 32'd3, 32'd1, 32'd6, 1'b0, "sll");
        step(32'h40415033, 32'hFFFFFFFA, 32'd33, 32'hFFFFFFFD, 1'b0, "sra33");
        step(32'h00415033, 32'd3, 32'd33, 32'd1, 1'b0, "srl33");
        step(32'h00411033, 32'd3, 32'd33, 32'd6, 1'b0, "sll33");
        step(32'h00338013, 32'd7, 32'hDEADBEEF, 32'd10, 1'b0, "addi");
        step(32'hFFF03013, 32'd0, 32'd5, 32'd1, 1'b0, "sltiu");
        step(32'hFFF02013, 32'd0, 32'd5, 32'd0, 1'b0, "slti");
        step(32'h40405013, 32'h80000000, 32'd0, 32'hF8000000, 1'b0, "srai");
        step(32'h00410033, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, "add_ovf");
        step(32'h00411033, 32'h12345678, 32'd0, 32'h12345678, 1'b0, "sll0");
        step(32'h40415033, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0, "sra31n");
        step(32'h40415033, 32'h7FFFFFFF, 32'd31, 32'h00000000, 1'b0, "sra31p");
        step(32'h00000063, 32'd2, 32'd4, 32'd0, 1'b1, "ill_opc");
        step(32'h02414033, 32'd2, 32'd4, 32'd0, 1'b1, "ill_mext");
        step(32'h40001013, 32'd2, 32'd4, 32'd0, 1'b1, "ill_slli");
        step(32'h00410033, 32'd2, 32'd4, 32'd6, 1'b0, "legal_after");

        // Asynchronous reset in the middle of back-to-back ADDs.
        code = 32'h00410033; rs1 = 32'd5; rs2 = 32'd6;
        #3 rst = 1'b1;
        #1;
        chk(rd, 32'd0, "async_rst.rd");
        repeat (2) @(posedge clk);
        #1;
        chk(rd, 32'd0, "rst_held.rd");
        chk({31'd0, illegal}, 32'd0, "rst_held.illegal");
        #2 rst = 1'b0;
        step(32'h00410033, 32'd10, 32'd20, 32'd30, 1'b0, "post_rst");

        // Reset must also clear a raised illegal flag.
        step(32'h00000063, 32'd1, 32'd1, 32'd0, 1'b1, "ill_pre_rst");
        #2 rst = 1'b1;
        #1;
        chk({31'd0, illegal}, 32'd0, "async_rst.illegal");
        #2 rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            c = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: c[6:0] = 7'h33;
                5, 6, 7, 8:    c[6:0] = 7'h13;
                default: ;
            endcase
            case ($urandom_range(0, 3))
                0: c[31:25] = 7'h00;
                1: c[31:25] = 7'h20;
                2: c[31:25] = 7'h01;
                default: ;
            endcase
            a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
            model(c, a, b, er, ei);
            step(c, a, b, er, ei, $sformatf("rand%0d_%h", i, c));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
